sha_padder: RTL and testbench

Byte-to-word message preprocessor for the single-block SHA-256 path. It collects UART RX bytes until a terminator byte arrives, then applies FIPS 180-4 padding: a 0x80 marker, zero fill, and the 64-bit big-endian bit length. It emits the resulting 512-bit block as 16 consecutive 32-bit words. It sits between the UART receiver and the message scheduler and drives the scheduler's `M_dv`/`M_i` inputs directly; there is no backpressure.

---
 rtl/sha_padder.sv | 148 ++++++++++++++
 tb/tb_sha_padder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sha_padder.sv
// Byte-to-word SHA-256 single-block padder.
// Collects bytes up to a terminator, then emits 16 padded 32-bit words.
module sha_padder #(
  parameter logic [7:0] TERM_BYTE = 8'h0A,
  parameter int         MAX_BYTES = 55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        valid_o,
  output logic [31:0] M_o,
  output logic        busy_o,
  output logic        overflow_o
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  len_q, len_d;
  logic [3:0]  idx_q, idx_d;
  logic        ovf_q, ovf_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic [31:0] m_q, m_d;
  logic [31:0] word;
  logic [7:0]  mem_q [MAX_BYTES];
  logic        we;
  logic [5:0]  waddr;
  logic        is_term;
  logic        full;

  assign is_term = (rx_data == TERM_BYTE);
  assign full    = (len_q >= 6'(MAX_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rx_valid) state_d = is_term ? EMIT : COLLECT;
      COLLECT: if (rx_valid && is_term) state_d = EMIT;
      EMIT:    if (idx_q == 4'd15) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    len_d = len_q;
    idx_d = '0;
    ovf_d = ovf_q;
    we    = 1'b0;
    waddr = len_q;
    unique case (state_q)
      IDLE: begin
        len_d = '0;
        if (rx_valid) begin
          ovf_d = 1'b0;
          if (!is_term) begin
            we    = 1'b1;
            waddr = '0;
            len_d = 6'd1;
          end
        end
      end
      COLLECT: begin
        if (rx_valid && !is_term) begin
          if (!full) begin
            we    = 1'b1;
            len_d = len_q + 6'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      EMIT: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) len_d = '0;
      end
      default: len_d = '0;
    endcase
  end

  // Bytes past len are masked, so stale storage never leaks out.
  always_comb begin
    logic [5:0] b;
    logic [7:0] bv;
    word = '0;
    b    = '0;
    bv   = '0;
    if (idx_q == 4'd15) begin
      word = {23'd0, len_q, 3'd0};
    end else if (idx_q != 4'd14) begin
      for (int j = 0; j < 4; j++) begin
        b = {idx_q, 2'(j)};
        if (b < len_q)       bv = mem_q[b];
        else if (b == len_q) bv = 8'h80;
        else                 bv = 8'h00;
        word[31-8*j -: 8] = bv;
      end
    end
  end

  always_comb begin
    valid_d = (state_q == EMIT);
    busy_d  = (state_q == EMIT);
    m_d     = valid_d ? word : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      m_q     <= '0;
    end else begin
      len_q   <= len_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      m_q     <= m_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_BYTES; k++) mem_q[k] <= '0;
    end else if (we) begin
      mem_q[waddr] <= rx_data;
    end
  end

  assign valid_o    = valid_q;
  assign busy_o     = busy_q;
  assign M_o        = m_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_sha_padder.sv
// Bench for sha_padder: directed and random messages
// checked against a block-level padding model.
module tb_sha_padder;

  localparam int MAXB = 55;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        valid_o;
  logic [31:0] M_o;
  logic        busy_o;
  logic        overflow_o;

  int total = 0;
  int bad = 0;
  logic [7:0] msg[$];

  sha_padder dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .valid_o(valid_o),
    .M_o(M_o),
    .busy_o(busy_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed msg bytes (no terminator) with random idle gaps.
  task automatic send_bytes(input bit gaps);
    for (int i = 0; i < msg.size(); i++) begin
      rx_valid = 1'b1;
      rx_data  = msg[i];
      tick();
      rx_valid = 1'b0;
      chk("ovf_collect", {31'd0, overflow_o}, {31'd0, (i + 1) > MAXB});
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  // Send msg plus terminator, then check the whole 16-word burst.
  task automatic run(input int inj, input bit gaps);
    logic [7:0]  blk [64];
    logic [31:0] exp [16];
    int n;
    int len;
    logic [63:0] bits;
    bit ovf;
    n   = msg.size();
    len = (n > MAXB) ? MAXB : n;
    ovf = (n > MAXB);
    for (int b = 0; b < 64; b++) blk[b] = 8'h00;
    for (int b = 0; b < len; b++) blk[b] = msg[b];
    blk[len] = 8'h80;
    bits = 64'(len) * 64'd8;
    for (int j = 0; j < 8; j++) blk[63-j] = bits[8*j +: 8];
    for (int k = 0; k < 16; k++)
      exp[k] = {blk[4*k], blk[4*k+1], blk[4*k+2], blk[4*k+3]};

    send_bytes(gaps);
    rx_valid = 1'b1;
    rx_data  = 8'h0A;
    tick();
    rx_valid = 1'b0;
    chk("valid_pre", {31'd0, valid_o}, 32'd0);
    chk("ovf_term", {31'd0, overflow_o}, {31'd0, ovf});
    for (int k = 0; k < 16; k++) begin
      if (k == inj) begin
        rx_valid = 1'b1;
        rx_data  = 8'h7A;
      end
      tick();
      rx_valid = 1'b0;
      chk($sformatf("valid_w%0d", k), {31'd0, valid_o}, 32'd1);
      chk($sformatf("busy_w%0d", k), {31'd0, busy_o}, 32'd1);
      chk($sformatf("word_w%0d", k), M_o, exp[k]);
      chk($sformatf("ovf_w%0d", k), {31'd0, overflow_o}, {31'd0, ovf});
    end
    tick();
    chk("valid_post", {31'd0, valid_o}, 32'd0);
    chk("busy_post", {31'd0, busy_o}, 32'd0);
    chk("m_post", M_o, 32'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_m", M_o, 32'd0);
    chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
  endtask

  task automatic set_abc();
    msg = {8'h61, 8'h62, 8'h63};
  endtask

  task automatic set_fill(input int n);
    msg = {};
    for (int i = 0; i < n; i++) msg.push_back(8'h41);
  endtask

  initial begin
    #3;
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    set_abc();
    run(-1, 1'b0);
    chk("abc_w0_const", M_o, 32'd0);

    msg = {};
    run(-1, 1'b0);

    set_fill(55);
    run(-1, 1'b0);

    set_fill(60);
    run(-1, 1'b0);

    set_abc();
    run(-1, 1'b0);

    set_abc();
    run(2, 1'b0);
    msg = {8'h61, 8'h62};
    run(-1, 1'b0);

    msg = {8'h61, 8'h62};
    send_bytes(1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    #1;
    rst_n = 1'b1;
    tick();
    set_abc();
    run(-1, 1'b0);

    set_fill(58);
    send_bytes(1'b0);
    chk("ovf_before_rst", {31'd0, overflow_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    #1;
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 20; t++) begin
      int n;
      logic [7:0] v;
      n = $urandom_range(0, 62);
      msg = {};
      for (int i = 0; i < n; i++) begin
        v = 8'($urandom_range(0, 255));
        if (v == 8'h0A) v = 8'h0B;
        msg.push_back(v);
      end
      run((t % 3 == 0) ? int'($urandom_range(0, 15)) : -1, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
